// File: rtl/packet_egress_scheduler_if.sv
// Egress scheduler bundle: upstream packet FIFO ports plus the egress byte stream.
// master = scheduler side, slave = FIFOs/sink side.
interface packet_egress_scheduler_if #(
    parameter int N_PORTS  = 4,
    parameter int ACTION_W = 64,
    parameter int PW       = $clog2(N_PORTS)
);
    logic [N_PORTS-1:0]          cfg_port_en;
    logic [N_PORTS-1:0]          req;
    logic [N_PORTS-1:0]          gnt;
    logic [N_PORTS-1:0]          in_valid;
    logic [8*N_PORTS-1:0]        in_data;
    logic [N_PORTS-1:0]          in_last;
    logic [N_PORTS-1:0]          in_ready;
    logic [ACTION_W*N_PORTS-1:0] in_action;
    logic                        out_valid;
    logic [7:0]                  out_data;
    logic                        out_last;
    logic                        out_sop;
    logic [ACTION_W-1:0]         out_action;
    logic [PW-1:0]               out_port;
    logic                        out_ready;
    logic                        err_trunc;

    modport master (
        input  cfg_port_en, req, in_valid, in_data, in_last, in_action, out_ready,
        output gnt, in_ready, out_valid, out_data, out_last, out_sop,
        output out_action, out_port, err_trunc
    );

    modport slave (
        output cfg_port_en, req, in_valid, in_data, in_last, in_action, out_ready,
        input  gnt, in_ready, out_valid, out_data, out_last, out_sop,
        input  out_action, out_port, err_trunc
    );
endinterface

// File: rtl/packet_egress_scheduler.sv
// Packet-granular round-robin scheduler merging N packet FIFOs onto one
// registered egress byte stream, with max-length truncation.
module packet_egress_scheduler #(
    parameter int N_PORTS     = 4,
    parameter int ACTION_W    = 64,
    parameter int MAX_PKT_LEN = 1518,
    parameter int CNT_W       = $clog2(MAX_PKT_LEN + 1)
) (
    input logic                       clk,
    input logic                       rst_n,
    packet_egress_scheduler_if.master bus
);
    localparam int PW = $clog2(N_PORTS);

    typedef enum logic [1:0] {IDLE, XFER, DISC} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        sel_q, sel_d;
    logic [PW-1:0]        pick, cand;
    logic                 found;
    logic [N_PORTS-1:0]   gnt_q, gnt_d;
    logic [N_PORTS-1:0]   elig, rdy;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ov_q, ov_d;
    logic                 ol_q, ol_d;
    logic                 os_q, os_d;
    logic                 err_q, err_d;
    logic [7:0]           od_q, od_d;
    logic [ACTION_W-1:0]  oa_q, oa_d;
    logic [7:0]           dat_a [N_PORTS];
    logic [ACTION_W-1:0]  act_a [N_PORTS];
    logic                 acc, lst;

    assign elig = bus.req & bus.cfg_port_en;

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            dat_a[i] = bus.in_data[8*i +: 8];
            act_a[i] = bus.in_action[ACTION_W*i +: ACTION_W];
        end
    end

    // First eligible port strictly after the pointer, wrapping around.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_PORTS; k++) begin
            cand = PW'((int'(ptr_q) + k) % N_PORTS);
            if (!found && elig[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        rdy = '0;
        unique case (state_q)
            XFER:    if (!ov_q || bus.out_ready) rdy = gnt_q;
            DISC:    rdy = gnt_q;
            default: rdy = '0;
        endcase
    end

    assign acc = bus.in_valid[sel_q] && rdy[sel_q];
    assign lst = bus.in_last[sel_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        od_d    = od_q;
        ol_d    = ol_q;
        os_d    = os_q;
        oa_d    = oa_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ov_q && bus.out_ready) ov_d = 1'b0;
                if (found) begin
                    sel_d   = pick;
                    gnt_d   = N_PORTS'(1) << pick;
                    oa_d    = act_a[pick];
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (acc) begin
                    ov_d  = 1'b1;
                    od_d  = dat_a[sel_q];
                    os_d  = (cnt_q == '0);
                    cnt_d = cnt_q + CNT_W'(1);
                    ol_d  = 1'b0;
                    if (lst) begin
                        ol_d    = 1'b1;
                        ptr_d   = sel_q;
                        gnt_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_q == CNT_W'(MAX_PKT_LEN - 1)) begin
                        ol_d    = 1'b1;
                        err_d   = 1'b1;
                        state_d = DISC;
                    end
                end else if (bus.out_ready) begin
                    ov_d = 1'b0;
                end
            end
            DISC: begin
                if (ov_q && bus.out_ready) ov_d = 1'b0;
                if (acc && lst) begin
                    ptr_d   = sel_q;
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PW'(N_PORTS - 1);
            sel_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ol_q    <= 1'b0;
            os_q    <= 1'b0;
            oa_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
            os_q    <= os_d;
            oa_q    <= oa_d;
            err_q   <= err_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.in_ready   = rdy;
    assign bus.out_valid  = ov_q;
    assign bus.out_data   = od_q;
    assign bus.out_last   = ol_q;
    assign bus.out_sop    = os_q;
    assign bus.out_action = oa_q;
    assign bus.out_port   = sel_q;
    assign bus.err_trunc  = err_q;
endmodule

// File: tb/tb_packet_egress_scheduler.sv
// Scoreboard bench for packet_egress_scheduler (MAX_PKT_LEN = 8).
// Expected beats are queued when a packet is granted and popped on egress.
module tb_packet_egress_scheduler;
    localparam int N    = 4;
    localparam int AW   = 64;
    localparam int MAXL = 8;

    typedef struct {
        logic [7:0]    d;
        logic          last;
        logic          sop;
        logic [1:0]    port;
        logic [AW-1:0] act;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    packet_egress_scheduler_if #(.N_PORTS(N), .ACTION_W(AW)) bus();

    packet_egress_scheduler #(
        .N_PORTS(N), .ACTION_W(AW), .MAX_PKT_LEN(MAXL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]    td [N];
    logic [AW-1:0] ta [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.in_data[8*i +: 8]    = td[i];
            bus.in_action[AW*i +: AW] = ta[i];
        end
    end

    beat_t sbq[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    last_cyc = 0;
    int    gap = -1;
    int    errs = 0;
    int    stalls = 0;
    int    mptr = N - 1;
    bit    mon_en = 1'b1;

    function automatic int rr_pick(input logic [N-1:0] el, input int ptr);
        for (int k = 1; k <= N; k++)
            if (el[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic monitor_loop();
        beat_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && bus.err_trunc) errs++;
            if (rst_n && mon_en && bus.out_valid && bus.out_ready) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected got data=%h port=%0d want none",
                             bus.out_data, bus.out_port);
                end else begin
                    e = sbq.pop_front();
                    if (bus.out_data !== e.d || bus.out_last !== e.last ||
                        bus.out_sop !== e.sop || bus.out_port !== e.port ||
                        bus.out_action !== e.act) begin
                        bad++;
                        $display("FAIL beat got d=%h l=%b s=%b p=%0d a=%h want d=%h l=%b s=%b p=%0d a=%h",
                                 bus.out_data, bus.out_last, bus.out_sop, bus.out_port,
                                 bus.out_action, e.d, e.last, e.sop, e.port, e.act);
                    end
                    if (e.sop) gap = cyc - last_cyc;
                    if (e.last) last_cyc = cyc;
                end
            end
        end
    endtask

    task automatic apply_reset();
        rst_n           = 1'b0;
        bus.req         = '0;
        bus.in_valid    = '0;
        bus.in_last     = '0;
        bus.out_ready   = 1'b1;
        bus.cfg_port_en = '1;
        for (int i = 0; i < N; i++) begin
            td[i] = '0;
            ta[i] = '0;
        end
        sbq.delete();
        mptr = N - 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pkt(input int p, input int n, input logic [7:0] base,
                             input logic [7:0] inc, input logic [AW-1:0] act);
        int    i;
        int    tmo;
        int    nout;
        beat_t e;
        i    = 0;
        tmo  = 0;
        nout = (n > MAXL) ? MAXL : n;
        ta[p] = act;
        td[p] = base;
        bus.in_last[p]  = (n == 1);
        bus.in_valid[p] = 1'b1;
        while (i < n) begin
            @(negedge clk);
            if (bus.in_ready[p]) begin
                if (i == 0) begin
                    total++;
                    if (bus.gnt !== (4'b0001 << p)) begin
                        bad++;
                        $display("FAIL grant got=%b want=%b", bus.gnt, 4'b0001 << p);
                    end
                    for (int j = 0; j < nout; j++) begin
                        e.d    = base + 8'(j) * inc;
                        e.last = (j == nout - 1);
                        e.sop  = (j == 0);
                        e.port = 2'(p);
                        e.act  = act;
                        sbq.push_back(e);
                    end
                end
                @(posedge clk);
                #1;
                if (i == 0) ta[p] = ~act;
                i++;
                tmo = 0;
                td[p] = base + 8'(i) * inc;
                bus.in_last[p] = (i == n - 1);
            end else if (++tmo > 100) begin
                total++;
                bad++;
                $display("FAIL accept_timeout port=%0d byte=%0d got no in_ready want in_ready", p, i);
                break;
            end
        end
        bus.in_valid[p] = 1'b0;
        bus.in_last[p]  = 1'b0;
        mptr = p;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", sbq.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (bus.out_valid !== 1'b0 || bus.err_trunc !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got v=%b e=%b want 0 0", bus.out_valid, bus.err_trunc);
        end
        total++;
        if (bus.gnt !== 4'b0 || bus.in_ready !== 4'b0) begin
            bad++;
            $display("FAIL reset_gnt got g=%b r=%b want 0 0", bus.gnt, bus.in_ready);
        end
        total++;
        if (bus.out_data !== 8'h0 || bus.out_sop !== 1'b0 || bus.out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_data got d=%h s=%b l=%b want 0", bus.out_data, bus.out_sop, bus.out_last);
        end
        total++;
        if (bus.out_port !== 2'd0 || bus.out_action !== '0) begin
            bad++;
            $display("FAIL reset_meta got p=%0d a=%h want 0 0", bus.out_port, bus.out_action);
        end
    endtask

    task automatic test_single();
        apply_reset();
        bus.req = 4'b0001;
        drive_pkt(0, 3, 8'hAA, 8'h11, 64'h11);
        bus.req = 4'b0000;
        wait_drain();
        total++;
        if (bus.out_action !== 64'h11) begin
            bad++;
            $display("FAIL action_hold got=%h want=%h", bus.out_action, 64'h11);
        end
    endtask

    task automatic test_round_robin();
        int p;
        apply_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            p = rr_pick(4'b1111, mptr);
            drive_pkt(p, 2, 8'(8'h10 * (k + 1)), 8'h01, 64'hA000 + 64'(k));
        end
        bus.req = 4'b0000;
        wait_drain();
    endtask

    task automatic stall_seq();
        bit         pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int         t;
        bit         prev;
        logic [7:0] held;
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        prev = 1'b0;
        held = bus.out_data;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk);
            #1 bus.out_ready = pat[j];
            @(negedge clk);
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                total++;
                if (bus.in_ready !== 4'b0) begin
                    bad++;
                    $display("FAIL stall_ready got=%b want=0000", bus.in_ready);
                end
                if (prev) begin
                    total++;
                    if (bus.out_data !== held) begin
                        bad++;
                        $display("FAIL stall_hold got=%h want=%h", bus.out_data, held);
                    end
                end
            end
            prev = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_stall();
        apply_reset();
        stalls = 0;
        bus.req = 4'b0100;
        fork
            drive_pkt(2, 4, 8'h41, 8'h01, 64'h5555);
            stall_seq();
        join
        bus.req = 4'b0000;
        wait_drain();
        total++;
        if (stalls < 2) begin
            bad++;
            $display("FAIL stall_count got=%0d want>=2", stalls);
        end
    endtask

    task automatic test_truncate();
        int e0;
        apply_reset();
        bus.req = 4'b0001;
        e0 = errs;
        drive_pkt(0, 12, 8'h01, 8'h01, 64'hBEEF);
        wait_drain();
        total++;
        if (errs - e0 !== 1) begin
            bad++;
            $display("FAIL trunc_pulse got=%0d want=1", errs - e0);
        end
        drive_pkt(0, 3, 8'h80, 8'h02, 64'hCAFE);
        drive_pkt(0, MAXL, 8'hC0, 8'h01, 64'hF00D);
        bus.req = 4'b0000;
        wait_drain();
        total++;
        if (errs - e0 !== 1) begin
            bad++;
            $display("FAIL trunc_exact got=%0d want=1", errs - e0);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.req = 4'b0100;
        drive_pkt(2, 3, 8'h20, 8'h01, 64'h1);
        drive_pkt(2, 2, 8'h30, 8'h01, 64'h2);
        bus.req = 4'b0000;
        wait_drain();
        total++;
        if (gap !== 2) begin
            bad++;
            $display("FAIL b2b_gap got=%0d want=2", gap);
        end
    endtask

    task automatic test_disabled_port();
        int p;
        apply_reset();
        bus.cfg_port_en = 4'b1101;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            p = rr_pick(4'b1101, mptr);
            drive_pkt(p, 1, 8'(8'h60 + k), 8'h01, 64'h700 + 64'(k));
        end
        bus.req = 4'b0000;
        wait_drain();
    endtask

    task automatic test_async_reset();
        int t;
        apply_reset();
        mon_en = 1'b0;
        bus.req = 4'b0010;
        td[1] = 8'h77;
        bus.in_valid[1] = 1'b1;
        t = 0;
        while (!bus.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL arst_start got out_valid=%b want 1", bus.out_valid);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL arst_valid got=%b want=0", bus.out_valid);
        end
        total++;
        if (bus.gnt !== 4'b0 || bus.in_ready !== 4'b0) begin
            bad++;
            $display("FAIL arst_gnt got g=%b r=%b want 0 0", bus.gnt, bus.in_ready);
        end
        bus.in_valid = '0;
        bus.req = '0;
        sbq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        mptr = N - 1;
        bus.req = 4'b0011;
        drive_pkt(0, 2, 8'hE0, 8'h01, 64'hD00D);
        bus.req = 4'b0000;
        wait_drain();
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.req         = '0;
        bus.in_valid    = '0;
        bus.in_last     = '0;
        bus.out_ready   = 1'b1;
        bus.cfg_port_en = '1;
        fork
            monitor_loop();
        join_none
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_truncate();
        test_back_to_back();
        test_disabled_port();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
